monta_carga: RTL and testbench
==============================

# monta_carga

Three-floor freight-elevator controller. Takes floor call buttons, per-floor limit switches and an emergency-stop input, and drives a two-bit motor command. It also drives a multiplexed two-digit 7-segment display showing the current floor and the travel direction. It sits between the cabin/landing I/O and the motor driver in the lift control top level.

## Interface
- REFRESH_DIV, default 66667: clock cycles per display digit slot (60 Hz-class refresh at 4 MHz).
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- P1, P2, P3  in  1 each  floor call buttons, active-high, level-sampled.
- FC1, FC2, FC3  in  1 each  floor limit switches, active-high; high while the cabin is at that floor.
- SP  in  1  emergency stop, active-high.
- motor  out  2  00 = stop, 01 = up, 10 = down; 11 is never driven.
- on  out  2  one-hot digit enable, active-high: 01 = digit 0 (floor), 10 = digit 1 (direction).
- Master_Display  out  7  segments {g,f,e,d,c,b,a}, active-high.

## Operation
- Position register `floor` (1..3):
  - Loads k whenever exactly FCk is high.
  - Holds when no FC is high or when more than one FC is high.
  - Reset value 1.
- Target register: 1..3 or none.
- States: IDLE, UP, DOWN, ESTOP.
- ESTOP:
  - SP high in any state enters ESTOP: motor 00, target cleared.
  - ESTOP returns to IDLE on the first cycle SP is low.
  - SP has priority over every other event.
- IDLE, call handling:
  - The highest-priority pressed button is accepted; priority P1 > P2 > P3.
  - Target > floor goes to UP; target < floor goes to DOWN.
  - A call for the current floor is ignored; the FSM stays in IDLE.
- UP/DOWN:
  - Calls are ignored while moving.
  - UP returns to IDLE when FC of the target is high, or when FC3 is high (overtravel guard). Target is cleared.
  - DOWN returns to IDLE when FC of the target is high, or when FC1 is high (overtravel guard). Target is cleared.
  - Arrival check takes priority over any simultaneous button press.
- motor is decoded from the registered state: UP gives 01, DOWN gives 10, otherwise 00.
- Display digit 0 shows the floor:
  - 1 = 0000110
  - 2 = 1011011
  - 3 = 1001111
- Display digit 1 shows the direction:
  - UP 'U' = 0111110
  - DOWN 'd' = 1011110
  - IDLE '-' = 1000000
  - ESTOP 'E' = 1111001
- Refresh counter:
  - Counts 0..REFRESH_DIV-1.
  - On wrap, `on` toggles 01↔10, and Master_Display switches to the matching digit in the same cycle.

## Timing
- Reset values:
  - State IDLE, floor 1, target none, motor 00.
  - Refresh counter 0, on 01, Master_Display 0000110.
- Latency: an input sampled at edge N changes state and motor at edge N, so the change is visible after edge N.
  - Button to motor start: 1 cycle.
  - FC arrival to motor 00: 1 cycle.
  - SP to motor 00: 1 cycle.
- Display content follows floor/state changes within 1 cycle, without waiting for a refresh slot.
- Reset mid-travel forces motor 00 at the next edge. The floor register restarts at 1 and is corrected by the next valid FC.

## Configuration
- MONTA_CARGA_DIR_DISPLAY_EN:
  - Defined: two-digit multiplex as described.
  - Undefined:
    - Refresh counter removed.
    - `on` is held at 01.
    - Master_Display always shows the floor digit.
    - The ESTOP/direction glyphs are never output.

## Test plan
- Reset with FC1=1, then pulse SP=1 for several cycles → motor 00, state ESTOP, digit 1 = 1111001. After SP=0 → IDLE, digit 1 = 1000000.
- From floor 1, pulse P2 → motor 01 one cycle later. With all FC low, motor stays 01. FC2=1 → motor 00 one cycle later, digit 0 = 1011011.
- At floor 2, P3, then FC3=1 → motor 01 then 00, floor 3. Release FC3 (all FC low) → floor stays 3, motor stays 00.
- From floor 3: P2 with FC2 → motor 10, then 00, floor 2. Then P1 with FC1 → motor 10, then 00, floor 1, digit 0 = 0000110.
- While moving up, assert SP → motor 00 next cycle. Release SP → IDLE. A new P3 press → motor 01.
- REFRESH_DIV=4 → `on` alternates 01/10 every 4 cycles, and Master_Display alternates floor and direction glyphs. Simultaneous P1+P3 at floor 2 → target 1, motor 10.

Source files
------------

// File: rtl/monta_carga_if.sv
// Cabin/landing I/O bundle for the monta_carga freight-lift controller.
// master: the controller; slave: the field side (buttons, switches, motor driver, display).
interface monta_carga_if;
  logic       P1;
  logic       P2;
  logic       P3;
  logic       FC1;
  logic       FC2;
  logic       FC3;
  logic       SP;
  logic [1:0] motor;
  logic [1:0] on;
  logic [6:0] Master_Display;

  modport master (
    input  P1, P2, P3, FC1, FC2, FC3, SP,
    output motor, on, Master_Display
  );

  modport slave (
    output P1, P2, P3, FC1, FC2, FC3, SP,
    input  motor, on, Master_Display
  );
endinterface

// File: rtl/monta_carga.sv
// Three-floor freight-lift controller: call/limit-switch FSM, motor command, 7-seg display.
// MONTA_CARGA_DIR_DISPLAY_EN enables the two-digit floor/direction multiplex.
module monta_carga #(
  parameter int unsigned REFRESH_DIV = 66667
) (
  input logic          clk,
  input logic          reset,
  monta_carga_if.master io
);

  typedef enum logic [1:0] {StIdle, StUp, StDown, StEstop} state_e;

  localparam logic [6:0] SegFloor1 = 7'b0000110;
  localparam logic [6:0] SegFloor2 = 7'b1011011;
  localparam logic [6:0] SegFloor3 = 7'b1001111;

  if (REFRESH_DIV < 1) begin : g_bad_div
    $error("REFRESH_DIV must be at least 1");
  end

  state_e     state_q, state_d;
  logic [1:0] floor_q, floor_d;
  // 0 encodes "no target"
  logic [1:0] target_q, target_d;
  logic [1:0] call;
  logic       target_fc;
  logic [6:0] floor_seg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      floor_q  <= 2'd1;
      target_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      target_q <= target_d;
    end
  end

  // Position only updates on an unambiguous single limit switch
  always_comb begin
    floor_d = floor_q;
    case ({io.FC3, io.FC2, io.FC1})
      3'b001:  floor_d = 2'd1;
      3'b010:  floor_d = 2'd2;
      3'b100:  floor_d = 2'd3;
      default: floor_d = floor_q;
    endcase
  end

  always_comb begin
    call = 2'd0;
    if (io.P1) begin
      call = 2'd1;
    end else if (io.P2) begin
      call = 2'd2;
    end else if (io.P3) begin
      call = 2'd3;
    end
  end

  always_comb begin
    case (target_q)
      2'd1:    target_fc = io.FC1;
      2'd2:    target_fc = io.FC2;
      2'd3:    target_fc = io.FC3;
      default: target_fc = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    if (io.SP) begin
      state_d  = StEstop;
      target_d = 2'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (call != 2'd0 && call > floor_q) begin
            state_d  = StUp;
            target_d = call;
          end else if (call != 2'd0 && call < floor_q) begin
            state_d  = StDown;
            target_d = call;
          end
        end
        StUp: begin
          if (target_fc || io.FC3) begin
            state_d  = StIdle;
            target_d = 2'd0;
          end
        end
        StDown: begin
          if (target_fc || io.FC1) begin
            state_d  = StIdle;
            target_d = 2'd0;
          end
        end
        StEstop: begin
          state_d  = StIdle;
          target_d = 2'd0;
        end
        default: begin
          state_d  = StIdle;
          target_d = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    case (state_q)
      StUp:    io.motor = 2'b01;
      StDown:  io.motor = 2'b10;
      default: io.motor = 2'b00;
    endcase
    case (floor_q)
      2'd2:    floor_seg = SegFloor2;
      2'd3:    floor_seg = SegFloor3;
      default: floor_seg = SegFloor1;
    endcase
  end

`ifdef MONTA_CARGA_DIR_DISPLAY_EN
  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic [1:0]      on_q;
  logic [6:0]      dir_seg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      on_q  <= 2'b01;
    end else if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
      cnt_q <= '0;
      on_q  <= {on_q[0], on_q[1]};
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    case (state_q)
      StUp:    dir_seg = 7'b0111110;
      StDown:  dir_seg = 7'b1011110;
      StEstop: dir_seg = 7'b1111001;
      default: dir_seg = 7'b1000000;
    endcase
  end

  assign io.on             = on_q;
  assign io.Master_Display = on_q[1] ? dir_seg : floor_seg;
`else
  assign io.on             = 2'b01;
  assign io.Master_Display = floor_seg;
`endif

endmodule

// File: tb/tb_monta_carga.sv
// Scoreboard bench for monta_carga: directed vectors push expectations, a monitor checks them.
module tb_monta_carga;

  localparam int Div = 4;

  localparam logic [6:0] SegF1   = 7'b0000110;
  localparam logic [6:0] SegF2   = 7'b1011011;
  localparam logic [6:0] SegF3   = 7'b1001111;
  localparam logic [6:0] SegUp   = 7'b0111110;
  localparam logic [6:0] SegDn   = 7'b1011110;
  localparam logic [6:0] SegIdle = 7'b1000000;
  localparam logic [6:0] SegStop = 7'b1111001;

  logic clk = 1'b0;
  logic reset;

  monta_carga_if bus ();

  monta_carga #(.REFRESH_DIV(Div)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         when;
    string      name;
    logic [1:0] motor;
    logic [6:0] fseg;
    logic [6:0] dseg;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests   = 0;
  int   fails   = 0;
  int   cyc     = 0;
  int   rst_cyc = 0;

  task automatic set_in(input logic r, input logic [2:0] p, input logic [2:0] fc, input logic sp);
    reset   = r;
    bus.P1  = p[0];
    bus.P2  = p[1];
    bus.P3  = p[2];
    bus.FC1 = fc[0];
    bus.FC2 = fc[1];
    bus.FC3 = fc[2];
    bus.SP  = sp;
  endtask

  // Drive one input vector and queue the outputs expected after the next rising edge.
  task automatic vec(input string name, input logic r, input logic [2:0] p, input logic [2:0] fc,
                     input logic sp, input logic [1:0] m, input logic [6:0] f,
                     input logic [6:0] d);
    exp_t e;
    @(negedge clk);
    set_in(r, p, fc, sp);
    e.when  = cyc + 1;
    e.name  = name;
    e.motor = m;
    e.fseg  = f;
    e.dseg  = d;
    sb.push_back(e);
  endtask

  task automatic check2(input string name, input string what, input logic [1:0] act,
                        input logic [1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s %s: got %b, expected %b", name, what, act, req);
    end
  endtask

  // Monitor: samples 2 time units after each rising edge.
  initial begin
    logic [1:0] exp_on;
    logic [6:0] exp_seg;
    int         phase;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset === 1'b1) rst_cyc = cyc;
      #2;
      while (sb.size() > 0 && sb[0].when < cyc) begin
        tests++;
        fails++;
        $display("FAIL %s: expectation never sampled (due %0d, now %0d)", sb[0].name, sb[0].when,
                 cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].when == cyc) begin
        mon_e = sb.pop_front();
`ifdef MONTA_CARGA_DIR_DISPLAY_EN
        phase   = ((cyc - rst_cyc) / Div) % 2;
        exp_on  = (phase == 1) ? 2'b10 : 2'b01;
        exp_seg = (phase == 1) ? mon_e.dseg : mon_e.fseg;
`else
        phase   = 0;
        exp_on  = 2'b01;
        exp_seg = mon_e.fseg;
`endif
        check2(mon_e.name, "motor", bus.motor, mon_e.motor);
        check2(mon_e.name, "on", bus.on, exp_on);
        tests++;
        if (bus.Master_Display !== exp_seg) begin
          fails++;
          $display("FAIL %s display: got %b, expected %b", mon_e.name, bus.Master_Display,
                   exp_seg);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    set_in(1'b1, 3'b000, 3'b001, 1'b0);
    //   name          rst  {P3P2P1} {FC3FC2FC1} SP  motor  floor  dir
    vec("rst0",        1'b1, 3'b000, 3'b001, 1'b0, 2'b00, SegF1, SegIdle);
    vec("rst1",        1'b1, 3'b000, 3'b001, 1'b0, 2'b00, SegF1, SegIdle);
    vec("sp0",         1'b0, 3'b000, 3'b001, 1'b1, 2'b00, SegF1, SegStop);
    vec("sp1",         1'b0, 3'b000, 3'b001, 1'b1, 2'b00, SegF1, SegStop);
    vec("sp2",         1'b0, 3'b000, 3'b001, 1'b1, 2'b00, SegF1, SegStop);
    vec("sp_rel",      1'b0, 3'b000, 3'b001, 1'b0, 2'b00, SegF1, SegIdle);
    vec("p2_start",    1'b0, 3'b010, 3'b001, 1'b0, 2'b01, SegF1, SegUp);
    vec("up_mid0",     1'b0, 3'b000, 3'b000, 1'b0, 2'b01, SegF1, SegUp);
    vec("up_mid1",     1'b0, 3'b000, 3'b000, 1'b0, 2'b01, SegF1, SegUp);
    vec("arr2_p3",     1'b0, 3'b100, 3'b010, 1'b0, 2'b00, SegF2, SegIdle);
    vec("idle2",       1'b0, 3'b000, 3'b010, 1'b0, 2'b00, SegF2, SegIdle);
    vec("p3_start",    1'b0, 3'b100, 3'b010, 1'b0, 2'b01, SegF2, SegUp);
    vec("up_23",       1'b0, 3'b000, 3'b000, 1'b0, 2'b01, SegF2, SegUp);
    vec("arr3",        1'b0, 3'b000, 3'b100, 1'b0, 2'b00, SegF3, SegIdle);
    vec("fc_rel0",     1'b0, 3'b000, 3'b000, 1'b0, 2'b00, SegF3, SegIdle);
    vec("fc_rel1",     1'b0, 3'b000, 3'b000, 1'b0, 2'b00, SegF3, SegIdle);
    vec("p2_down",     1'b0, 3'b010, 3'b100, 1'b0, 2'b10, SegF3, SegDn);
    vec("down_32",     1'b0, 3'b000, 3'b000, 1'b0, 2'b10, SegF3, SegDn);
    vec("arr2d",       1'b0, 3'b000, 3'b010, 1'b0, 2'b00, SegF2, SegIdle);
    vec("p1_down",     1'b0, 3'b001, 3'b010, 1'b0, 2'b10, SegF2, SegDn);
    vec("down_21",     1'b0, 3'b000, 3'b000, 1'b0, 2'b10, SegF2, SegDn);
    vec("arr1",        1'b0, 3'b000, 3'b001, 1'b0, 2'b00, SegF1, SegIdle);
    vec("same_floor",  1'b0, 3'b001, 3'b001, 1'b0, 2'b00, SegF1, SegIdle);
    vec("p3_up",       1'b0, 3'b100, 3'b001, 1'b0, 2'b01, SegF1, SegUp);
    vec("up_13",       1'b0, 3'b000, 3'b000, 1'b0, 2'b01, SegF1, SegUp);
    vec("sp_move",     1'b0, 3'b000, 3'b000, 1'b1, 2'b00, SegF1, SegStop);
    vec("sp_clear",    1'b0, 3'b000, 3'b000, 1'b0, 2'b00, SegF1, SegIdle);
    vec("p3_again",    1'b0, 3'b100, 3'b000, 1'b0, 2'b01, SegF1, SegUp);
    vec("arr3b",       1'b0, 3'b000, 3'b100, 1'b0, 2'b00, SegF3, SegIdle);
    vec("multi_fc",    1'b0, 3'b000, 3'b110, 1'b0, 2'b00, SegF3, SegIdle);
    vec("p2_from3",    1'b0, 3'b010, 3'b100, 1'b0, 2'b10, SegF3, SegDn);
    vec("arr2b",       1'b0, 3'b000, 3'b010, 1'b0, 2'b00, SegF2, SegIdle);
    vec("p1p3_prio",   1'b0, 3'b101, 3'b010, 1'b0, 2'b10, SegF2, SegDn);
    vec("down_prio",   1'b0, 3'b000, 3'b000, 1'b0, 2'b10, SegF2, SegDn);
    vec("arr1b",       1'b0, 3'b000, 3'b001, 1'b0, 2'b00, SegF1, SegIdle);
    vec("p2_up",       1'b0, 3'b010, 3'b001, 1'b0, 2'b01, SegF1, SegUp);
    vec("over_up",     1'b0, 3'b000, 3'b100, 1'b0, 2'b00, SegF3, SegIdle);
    vec("p2_dn",       1'b0, 3'b010, 3'b100, 1'b0, 2'b10, SegF3, SegDn);
    vec("over_dn",     1'b0, 3'b000, 3'b001, 1'b0, 2'b00, SegF1, SegIdle);
    vec("p3_mid",      1'b0, 3'b100, 3'b001, 1'b0, 2'b01, SegF1, SegUp);
    vec("mid",         1'b0, 3'b000, 3'b000, 1'b0, 2'b01, SegF1, SegUp);
    vec("pass2",       1'b0, 3'b000, 3'b010, 1'b0, 2'b01, SegF2, SegUp);
    vec("rst_mid",     1'b1, 3'b000, 3'b000, 1'b0, 2'b00, SegF1, SegIdle);
    vec("rst_fix",     1'b0, 3'b000, 3'b100, 1'b0, 2'b00, SegF3, SegIdle);
    vec("hold",        1'b0, 3'b000, 3'b000, 1'b0, 2'b00, SegF3, SegIdle);

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
